// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK sequencer: command opcodes and controller states.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_count(input op_e op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_bank.sv
// WIDTH-bit bank of jk_flipflop cells sharing clock and reset.
module jk_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ff
        jk_flipflop u_ff (
            .clk  (clk),
            .rst  (rst),
            .j    (j[g]),
            .k    (k[g]),
            .q    (q[g]),
            .qbar (qbar[g])
        );
    end

endmodule

// File: rtl/jk_flipflop.sv
// Single JK flip-flop cell: 00 hold, 01 reset, 10 set, 11 toggle; async active-high reset.
module jk_flipflop (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a JK flip-flop bank (load / count up / count down / clear).
// Optional macro JK_SAT_EN: counts saturate at the rails and raise the sticky sat flag.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    state_e             r_state, w_next;
    op_e                r_op;
    op_e                w_cmd_op;
    logic [WIDTH-1:0]   r_data;
    logic [LEN_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_j, w_k, w_q, w_qbar;
    logic               w_accept, w_last, w_blocked;

    // Bit i toggles when every lower bit of v is 1 (v = q counts up, v = ~q counts down).
    function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        logic             acc;
        m   = '0;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = acc;
            acc  = acc & v[i];
        end
        return m;
    endfunction

    assign w_cmd_op = op_e'(cmd_op);
    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_last   = (r_op == OP_LOAD) || (r_op == OP_CLEAR) || (r_cnt == LEN_W'(1));

`ifdef JK_SAT_EN
    logic r_sat;

    assign w_blocked = ((r_op == OP_UP) && (&w_q)) || ((r_op == OP_DOWN) && ~(|w_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_accept && !is_count(w_cmd_op)) begin
            r_sat <= 1'b0;
        end else if ((r_state == ST_EXEC) && w_blocked) begin
            r_sat <= 1'b1;
        end
    end

    assign sat = r_sat;
`else
    assign w_blocked = 1'b0;
    assign sat       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        w_j    = '0;
        w_k    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_next = (is_count(w_cmd_op) && (cmd_len == '0)) ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                case (r_op)
                    OP_LOAD: begin
                        w_j = r_data;
                        w_k = ~r_data;
                    end
                    OP_UP: begin
                        w_j = carry_mask(w_q);
                        w_k = w_j;
                    end
                    OP_DOWN: begin
                        w_j = carry_mask(w_qbar);
                        w_k = w_j;
                    end
                    default: w_k = '1;
                endcase
                if (w_blocked) begin
                    w_j = '0;
                    w_k = '0;
                end
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Command fields are captured at the handshake; the step counter runs only in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_LOAD;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op   <= w_cmd_op;
            r_data <= cmd_data;
            r_cnt  <= cmd_len;
        end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - LEN_W'(1);
        end
    end

    jk_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .j    (w_j),
        .k    (w_k),
        .q    (w_q),
        .qbar (w_qbar)
    );

    assign q         = w_q;
    assign qbar      = w_qbar;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_EXEC) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed self-checking bench for jk_seq_ctrl (WIDTH=4, LEN_W=8); expectations follow JK_SAT_EN.
module tb_jk_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
`ifdef JK_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [WIDTH-1:0] q, qbar;
    logic             busy, done, sat;

    int n_cmp = 0;
    int n_mis = 0;

    logic [11:0] w_obs;
    logic [11:0] exp_v;
    assign w_obs = {q, qbar, busy, done, cmd_ready, sat};

    jk_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q         (q),
        .qbar      (qbar),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // Packed expectation in the order q, qbar, busy, done, cmd_ready, sat.
    function automatic logic [11:0] exp_of(input logic [3:0] eq, input logic eb, input logic ed,
                                           input logic er, input logic es);
        return {eq, ~eq, eb, ed, er, es};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait for cmd_ready, and return 1 time unit after the accepting edge E0.
    task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l);
        int w;
        w = 0;
        cmd_op = op; cmd_data = d; cmd_len = l; cmd_valid = 1'b1;
        while (!cmd_ready && w < 64) begin
            tick();
            w++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL send_wait_ready: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, w);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        exp_v = exp_of(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL reset_held: observed %b expected %b", w_obs, exp_v); end
        rst = 1'b0;
        tick();
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL reset_released: observed %b expected %b", w_obs, exp_v); end
    endtask

    task automatic test_load();
        send(2'd0, 4'b1010, 8'd0);
        exp_v = exp_of(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL load_e0: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL load_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL load_e2: observed %b expected %b", w_obs, exp_v); end
    endtask

    task automatic test_up_wrap();
        send(2'd0, 4'hE, 8'd0);
        tick(); tick();
        send(2'd1, 4'h0, 8'd3);
        exp_v = exp_of(4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL up_e0: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL up_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(SAT ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL up_e2_wrap: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(SAT ? 4'hF : 4'h1, 1'b1, 1'b1, 1'b0, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL up_e3_done: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(SAT ? 4'hF : 4'h1, 1'b0, 1'b0, 1'b1, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL up_e4_idle: observed %b expected %b", w_obs, exp_v); end
    endtask

    task automatic test_down_zero();
        send(2'd3, 4'h9, 8'd5);
        tick();
        exp_v = exp_of(4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL clear_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        send(2'd2, 4'h0, 8'd2);
        tick();
        exp_v = exp_of(SAT ? 4'h0 : 4'hF, 1'b1, 1'b0, 1'b0, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL down_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(SAT ? 4'h0 : 4'hE, 1'b1, 1'b1, 1'b0, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL down_e2_done: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(SAT ? 4'h0 : 4'hE, 1'b0, 1'b0, 1'b1, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL down_e3_idle: observed %b expected %b", w_obs, exp_v); end
    endtask

    task automatic test_len0_backpressure();
        logic [3:0] qv;
        qv = SAT ? 4'h0 : 4'hE;
        send(2'd1, 4'h0, 8'd0);
        exp_v = exp_of(qv, 1'b1, 1'b1, 1'b0, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL len0_e0_done: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(qv, 1'b0, 1'b0, 1'b1, SAT);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL len0_e1_idle: observed %b expected %b", w_obs, exp_v); end
        // LOAD 3 accepted now, then an UP len=2 held valid through the busy window.
        cmd_op = 2'd0; cmd_data = 4'h3; cmd_len = 8'd0; cmd_valid = 1'b1;
        tick();
        cmd_op = 2'd1; cmd_data = 4'hC; cmd_len = 8'd2;
        exp_v = exp_of(qv, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_load_e0: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_load_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_held_ready: observed %b expected %b", w_obs, exp_v); end
        tick();
        cmd_valid = 1'b0;
        exp_v = exp_of(4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_up_accept: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_up_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_up_e2_done: observed %b expected %b", w_obs, exp_v); end
        tick(); tick();
        exp_v = exp_of(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL bp_single_accept: observed %b expected %b", w_obs, exp_v); end
    endtask

    task automatic test_reset_mid_op();
        int n_done;
        send(2'd1, 4'h0, 8'd10);
        tick(); tick(); tick(); tick();
        exp_v = exp_of(4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL rmid_after4: observed %b expected %b", w_obs, exp_v); end
        rst = 1'b1;
        #1;
        exp_v = exp_of(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL rmid_async: observed %b expected %b", w_obs, exp_v); end
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) n_done++;
        end
        n_cmp++; if (n_done != 0) begin n_mis++; $display("FAIL rmid_no_done: %0d cycles busy/done after reset, expected 0", n_done); end
        send(2'd0, 4'h5, 8'd0);
        tick();
        exp_v = exp_of(4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL rmid_load_e1: observed %b expected %b", w_obs, exp_v); end
        tick();
        exp_v = exp_of(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (w_obs !== exp_v) begin n_mis++; $display("FAIL rmid_load_e2: observed %b expected %b", w_obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up_wrap();
        test_down_zero();
        test_len0_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
